// File: rtl/cart_loader.sv
// rtl/cart_loader.sv - cartridge download receiver: ioctl stream to ROM write port, power-of-two padding
module cart_loader #(
  parameter int          ADDR_W     = 16,
  parameter logic [7:0]  CART_INDEX = 8'd1,
  parameter int          MIN_LOG2   = 14,
  parameter logic [7:0]  PAD_BYTE   = 8'hFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              busy,
  output logic              cart_loaded,
  output logic [ADDR_W-1:0] rom_mask,
  output logic              error
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_PAD, S_DONE} state_t;

  localparam logic [ADDR_W:0]   ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  state_t          state;
  logic            dl_q;
  logic [ADDR_W:0] count;
  logic [ADDR_W:0] size;
  logic [ADDR_W:0] pad_ptr;
  logic [ADDR_W:0] size_c;
  logic [ADDR_W:0] addr_p1;
  logic [ADDR_W:0] pad_nxt;
  logic            dl_rise;
  logic            dl_fall;
  logic            addr_oob;

  assign dl_rise  = ioctl_download & ~dl_q & (ioctl_index == CART_INDEX);
  assign dl_fall  = ~ioctl_download & dl_q;
  assign addr_oob = |ioctl_addr[24:ADDR_W];

  // In LOAD/DRAIN mem_we doubles as the holding-register valid bit.
  assign ioctl_wait = mem_we | ((state != S_IDLE) && (state != S_LOAD));

  always_comb begin
    addr_p1 = {1'b0, ioctl_addr[ADDR_W-1:0]} + ONE;
    pad_nxt = pad_ptr + ONE;
    size_c  = '0;
    size_c[MIN_LOG2] = 1'b1;
    for (int i = 0; i < ADDR_W; i++) begin
      if (size_c < count) size_c = {size_c[ADDR_W-1:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      dl_q        <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      busy        <= 1'b0;
      cart_loaded <= 1'b0;
      error       <= 1'b0;
      rom_mask    <= '1;
      count       <= '0;
      size        <= '0;
      pad_ptr     <= '0;
    end else begin
      dl_q <= ioctl_download;
      if (dl_rise && (state == S_IDLE || state == S_DRAIN || state == S_PAD)) begin
        // New download (or restart) drops whatever write was pending.
        state       <= S_LOAD;
        mem_we      <= 1'b0;
        count       <= '0;
        pad_ptr     <= '0;
        error       <= 1'b0;
        cart_loaded <= 1'b0;
        rom_mask    <= '1;
        busy        <= 1'b1;
      end else begin
        case (state)
          S_LOAD: begin
            if (mem_we && mem_ready) mem_we <= 1'b0;
            if (ioctl_wr) begin
              if (mem_we || addr_oob) begin
                error <= 1'b1;
              end else begin
                mem_we   <= 1'b1;
                mem_addr <= ioctl_addr[ADDR_W-1:0];
                mem_din  <= ioctl_dout;
                if (addr_p1 > count) count <= addr_p1;
              end
            end
            if (dl_fall) state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (mem_we) begin
              if (mem_ready) mem_we <= 1'b0;
            end else if (count == '0) begin
              state       <= S_IDLE;
              busy        <= 1'b0;
              cart_loaded <= 1'b0;
            end else begin
              size    <= size_c;
              pad_ptr <= count;
              if (count != size_c) begin
                mem_we   <= 1'b1;
                mem_addr <= count[ADDR_W-1:0];
                mem_din  <= PAD_BYTE;
              end
              state <= S_PAD;
            end
          end
          S_PAD: begin
            if (!mem_we) begin
              state <= S_DONE;
            end else if (mem_ready) begin
              pad_ptr <= pad_nxt;
              if (pad_nxt == size) begin
                mem_we <= 1'b0;
                state  <= S_DONE;
              end else begin
                mem_addr <= pad_nxt[ADDR_W-1:0];
              end
            end
          end
          S_DONE: begin
            // A full-size image gives size[ADDR_W-1:0]==0, which wraps to the all-ones mask.
            rom_mask    <= error ? '1 : (size[ADDR_W-1:0] - ONE_A);
            cart_loaded <= ~error;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cart_loader.sv
// tb/tb_cart_loader.sv - directed table-driven bench for cart_loader (scaled: ADDR_W=10, MIN_LOG2=8)
module tb_cart_loader;

  localparam int AW    = 10;
  localparam int ROM_N = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index = 8'd0;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          ioctl_wait;
  logic          mem_ready = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          busy;
  logic          cart_loaded;
  logic [AW-1:0] rom_mask;
  logic          error;

  cart_loader #(.ADDR_W(AW), .CART_INDEX(8'd1), .MIN_LOG2(8), .PAD_BYTE(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .cart_loaded(cart_loaded), .rom_mask(rom_mask), .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int timeouts = 0, stall_viol = 0, idle_viol = 0, total_writes = 0;
  int         wr_cnt [ROM_N];
  logic [7:0] rom    [ROM_N];

  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [7:0]    prev_din = '0;

  // ROM-side model: records every accepted write and watches handshake rules.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_we && !busy) idle_viol++;
      if (prev_stall && (!mem_we || mem_addr != prev_addr || mem_din != prev_din)) stall_viol++;
      prev_stall = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_din   = mem_din;
      if (mem_we && mem_ready) begin
        rom[mem_addr] = mem_din;
        wr_cnt[mem_addr]++;
        total_writes++;
      end
    end
  end

  function automatic logic [7:0] pat(input int a);
    return 8'(a * 7 + 3);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < ROM_N; i++) begin
      wr_cnt[i] = 0;
      rom[i]    = 8'h00;
    end
    total_writes = 0;
    stall_viol   = 0;
    idle_viol    = 0;
    timeouts     = 0;
  endtask

  task automatic wait_no_wait();
    int g = 0;
    while (ioctl_wait && g < 200) begin
      tick();
      g++;
    end
    if (g >= 200) timeouts++;
  endtask

  task automatic send_byte(input int a);
    wait_no_wait();
    ioctl_addr = 25'(a);
    ioctl_dout = pat(a);
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    tick();
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl_and_wait();
    int g = 0;
    ioctl_download = 1'b0;
    tick();
    while (busy && g < 5000) begin
      tick();
      g++;
    end
    if (g >= 5000) timeouts++;
    tick();
    tick();
  endtask

  task automatic verify(input string tag, input int n, input int exp_writes, input int exp_pad,
                        input int exp_mask, input int exp_loaded, input int exp_error);
    int bad = 0, pads = 0;
    for (int a = 0; a < ROM_N; a++) begin
      int         exp_w;
      logic [7:0] exp_b;
      exp_w = (a < exp_writes) ? 1 : 0;
      exp_b = (a < n) ? pat(a) : 8'hFF;
      if (a >= n) pads += wr_cnt[a];
      if (wr_cnt[a] != exp_w) bad++;
      else if (exp_w == 1 && rom[a] != exp_b) bad++;
    end
    check($sformatf("%s writes", tag), total_writes, exp_writes);
    check($sformatf("%s pad_writes", tag), pads, exp_pad);
    check($sformatf("%s rom_content_bad", tag), bad, 0);
    check($sformatf("%s rom_mask", tag), int'(rom_mask), exp_mask);
    check($sformatf("%s cart_loaded", tag), int'(cart_loaded), exp_loaded);
    check($sformatf("%s error", tag), int'(error), exp_error);
    check($sformatf("%s busy", tag), int'(busy), 0);
    check($sformatf("%s timeouts", tag), timeouts, 0);
    check($sformatf("%s stall_violations", tag), stall_viol, 0);
    check($sformatf("%s we_in_idle", tag), idle_viol, 0);
  endtask

  typedef struct {
    int         n;
    logic [7:0] idx;
    int         writes;
    int         pad;
    int         mask;
    int         loaded;
    int         err;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{n: 100,  idx: 8'd2, writes: 0,    pad: 0,   mask: 'h3FF, loaded: 0, err: 0};
    vecs[1] = '{n: 512,  idx: 8'd1, writes: 512,  pad: 0,   mask: 'h1FF, loaded: 1, err: 0};
    vecs[2] = '{n: 313,  idx: 8'd1, writes: 512,  pad: 199, mask: 'h1FF, loaded: 1, err: 0};
    vecs[3] = '{n: 64,   idx: 8'd1, writes: 256,  pad: 192, mask: 'h0FF, loaded: 1, err: 0};
    vecs[4] = '{n: 1024, idx: 8'd1, writes: 1024, pad: 0,   mask: 'h3FF, loaded: 1, err: 0};
    vecs[5] = '{n: 1100, idx: 8'd1, writes: 1024, pad: 0,   mask: 'h3FF, loaded: 0, err: 1};
    vecs[6] = '{n: 257,  idx: 8'd1, writes: 512,  pad: 255, mask: 'h1FF, loaded: 1, err: 0};
    vecs[7] = '{n: 1,    idx: 8'd1, writes: 256,  pad: 255, mask: 'h0FF, loaded: 1, err: 0};
    vecs[8] = '{n: 0,    idx: 8'd1, writes: 0,    pad: 0,   mask: 'h3FF, loaded: 0, err: 0};

    clear_model();
    tick();
    tick();
    check("reset ioctl_wait", int'(ioctl_wait), 0);
    check("reset mem_we", int'(mem_we), 0);
    check("reset busy", int'(busy), 0);
    check("reset cart_loaded", int'(cart_loaded), 0);
    check("reset error", int'(error), 0);
    check("reset rom_mask", int'(rom_mask), 'h3FF);
    check("reset mem_addr", int'(mem_addr), 0);
    check("reset mem_din", int'(mem_din), 0);
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 9; v++) begin
      clear_model();
      start_dl(vecs[v].idx);
      for (int a = 0; a < vecs[v].n; a++) send_byte(a);
      end_dl_and_wait();
      verify($sformatf("vec%0d", v), vecs[v].n, vecs[v].writes, vecs[v].pad,
             vecs[v].mask, vecs[v].loaded, vecs[v].err);
    end

    // ROM port stalls for 5 cycles with a byte held.
    clear_model();
    start_dl(8'd1);
    for (int a = 0; a < 20; a++) send_byte(a);
    wait_no_wait();
    mem_ready = 1'b0;
    send_byte(20);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d ioctl_wait", c), int'(ioctl_wait), 1);
      check($sformatf("stall%0d mem_we", c), int'(mem_we), 1);
      check($sformatf("stall%0d mem_addr", c), int'(mem_addr), 20);
      check($sformatf("stall%0d mem_din", c), int'(mem_din), int'(pat(20)));
      tick();
    end
    mem_ready = 1'b1;
    for (int a = 21; a < 40; a++) send_byte(a);
    end_dl_and_wait();
    verify("stall", 40, 256, 216, 'h0FF, 1, 0);

    // Reset pulse while padding.
    begin
      int g = 0;
      int w;
      clear_model();
      start_dl(8'd1);
      for (int a = 0; a < 10; a++) send_byte(a);
      ioctl_download = 1'b0;
      tick();
      while (!(busy && mem_we && mem_addr >= AW'(10)) && g < 100) begin
        tick();
        g++;
      end
      check("pad reached", int'(g < 100), 1);
      reset_n = 1'b0;
      #1;
      check("rst mem_we", int'(mem_we), 0);
      check("rst busy", int'(busy), 0);
      w = total_writes;
      tick();
      reset_n = 1'b1;
      repeat (20) tick();
      check("rst no_writes", total_writes, w);
      check("rst cart_loaded", int'(cart_loaded), 0);
      check("rst rom_mask", int'(rom_mask), 'h3FF);
      check("rst busy_after", int'(busy), 0);
      check("rst ioctl_wait", int'(ioctl_wait), 0);
      check("rst error", int'(error), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
